// File: rtl/i2c_receiver.sv
// rtl/i2c_receiver.sv - oversampling write-only I2C target with address match, ACK/NACK and byte handoff
// Optional majority glitch filter on SCL/SDA: define I2C_RX_GLITCH_FILTER_EN.
module i2c_receiver #(
    parameter logic [6:0] ADDR = 7'h50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl,
    input  logic       sda_in,
    output logic       sda_oe,
    input  logic       rx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       addr_match,
    output logic       stop_det,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_DATA,
        S_DATA_ACK,
        S_DATA_NACK,
        S_IGNORE
    } state_t;

    // Synchronizers reset to the idle-high bus level so reset never fakes an edge.
    logic scl_s1_q, scl_s2_q, sda_s1_q, sda_s2_q;
    logic scl_prev_q, sda_prev_q;
    logic scl_line, sda_line;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_s1_q <= 1'b1;
            scl_s2_q <= 1'b1;
            sda_s1_q <= 1'b1;
            sda_s2_q <= 1'b1;
        end else begin
            scl_s1_q <= scl;
            scl_s2_q <= scl_s1_q;
            sda_s1_q <= sda_in;
            sda_s2_q <= sda_s1_q;
        end
    end

`ifdef I2C_RX_GLITCH_FILTER_EN
    logic [1:0] scl_hist_q, sda_hist_q;
    logic       scl_filt_q, sda_filt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_hist_q <= 2'b11;
            sda_hist_q <= 2'b11;
            scl_filt_q <= 1'b1;
            sda_filt_q <= 1'b1;
        end else begin
            scl_hist_q <= {scl_hist_q[0], scl_s2_q};
            sda_hist_q <= {sda_hist_q[0], sda_s2_q};
            scl_filt_q <= (scl_s2_q & scl_hist_q[0]) | (scl_s2_q & scl_hist_q[1]) |
                          (scl_hist_q[0] & scl_hist_q[1]);
            sda_filt_q <= (sda_s2_q & sda_hist_q[0]) | (sda_s2_q & sda_hist_q[1]) |
                          (sda_hist_q[0] & sda_hist_q[1]);
        end
    end

    assign scl_line = scl_filt_q;
    assign sda_line = sda_filt_q;
`else
    assign scl_line = scl_s2_q;
    assign sda_line = sda_s2_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_prev_q <= scl_line;
            sda_prev_q <= sda_line;
        end
    end

    logic scl_rise, scl_fall, sda_rise, sda_fall, start_hit, stop_hit;
    assign scl_rise  = scl_line & ~scl_prev_q;
    assign scl_fall  = ~scl_line & scl_prev_q;
    assign sda_rise  = sda_line & ~sda_prev_q;
    assign sda_fall  = ~sda_line & sda_prev_q;
    assign start_hit = sda_fall & scl_line & scl_prev_q;
    assign stop_hit  = sda_rise & scl_line & scl_prev_q;

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       done_q, done_d;
    logic       ack_q, ack_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       addr_match_q, addr_match_d;
    logic       stop_det_q, stop_det_d;
    logic       busy_q, busy_d;
    logic       sda_oe_q, sda_oe_d;
    logic [7:0] shift_next;

    assign shift_next = {shift_q[6:0], sda_line};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= 3'd0;
            shift_q      <= 8'h00;
            done_q       <= 1'b0;
            ack_q        <= 1'b0;
            rx_data_q    <= 8'h00;
            rx_valid_q   <= 1'b0;
            addr_match_q <= 1'b0;
            stop_det_q   <= 1'b0;
            busy_q       <= 1'b0;
            sda_oe_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            done_q       <= done_d;
            ack_q        <= ack_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            addr_match_q <= addr_match_d;
            stop_det_q   <= stop_det_d;
            busy_q       <= busy_d;
            sda_oe_q     <= sda_oe_d;
        end
    end

    // done_q marks "8 bits shifted, waiting for the SCL fall that opens the ACK slot".
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        shift_d      = shift_q;
        done_d       = done_q;
        ack_d        = ack_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = 1'b0;
        addr_match_d = addr_match_q;
        stop_det_d   = 1'b0;
        busy_d       = busy_q;
        sda_oe_d     = sda_oe_q;

        if (start_hit) begin
            state_d      = S_ADDR;
            cnt_d        = 3'd0;
            done_d       = 1'b0;
            addr_match_d = 1'b0;
            sda_oe_d     = 1'b0;
            busy_d       = 1'b1;
        end else if (stop_hit) begin
            state_d      = S_IDLE;
            cnt_d        = 3'd0;
            done_d       = 1'b0;
            addr_match_d = 1'b0;
            sda_oe_d     = 1'b0;
            busy_d       = 1'b0;
            stop_det_d   = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: ;
                S_ADDR: begin
                    if (scl_rise && !done_q) begin
                        shift_d = shift_next;
                        cnt_d   = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) done_d = 1'b1;
                    end else if (scl_fall && done_q) begin
                        done_d = 1'b0;
                        if (shift_q[7:1] == ADDR && !shift_q[0]) begin
                            state_d      = S_ADDR_ACK;
                            sda_oe_d     = 1'b1;
                            addr_match_d = 1'b1;
                        end else begin
                            state_d = S_IGNORE;
                        end
                    end
                end
                S_ADDR_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d = 1'b0;
                        state_d  = S_DATA;
                    end
                end
                S_DATA: begin
                    if (scl_rise && !done_q) begin
                        shift_d = shift_next;
                        cnt_d   = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            done_d = 1'b1;
                            ack_d  = rx_ready;
                            if (rx_ready) begin
                                rx_data_d  = shift_next;
                                rx_valid_d = 1'b1;
                            end
                        end
                    end else if (scl_fall && done_q) begin
                        done_d = 1'b0;
                        if (ack_q) begin
                            state_d  = S_DATA_ACK;
                            sda_oe_d = 1'b1;
                        end else begin
                            state_d = S_DATA_NACK;
                        end
                    end
                end
                S_DATA_ACK, S_DATA_NACK: begin
                    if (scl_fall) begin
                        sda_oe_d = 1'b0;
                        state_d  = S_DATA;
                    end
                end
                S_IGNORE: sda_oe_d = 1'b0;
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign sda_oe     = sda_oe_q;
    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign addr_match = addr_match_q;
    assign stop_det   = stop_det_q;
    assign busy       = busy_q;

endmodule
